mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the processor data-memory bus, downstream of the core (parallel to dmem).

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/mmio_uart_tx_if.sv | 16 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/mmio_uart_tx.sv | 210 +++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and register-map constants for the MMIO UART transmitter
// Purpose: FSM state encoding, register offsets (addr[3:2]) and STATUS bit positions.
// Ports: none (package).
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] OFS_TXDATA  = 2'd0;
   localparam logic [1:0] OFS_STATUS  = 2'd1;
   localparam logic [1:0] OFS_BAUDDIV = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - data-memory bus slice seen by the UART transmitter
// Purpose: groups the core-side write strobe, address, write data and the
//          UART's combinational read data / window hit.
// Ports (modports):
//   master : drives we, addr, wd; receives rd, hit
//   slave  : receives we, addr, wd; drives rd, hit
interface mmio_uart_tx_if;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        hit;

   modport master (output we, output addr, output wd, input rd, input hit);
   modport slave  (input we, input addr, input wd, output rd, output hit);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: buffers TX bytes between the bus and the serialiser.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push_i, wdata_i     write request and data (accepted when not full, or full with same-cycle pop)
//   pop_i, rdata_o      read request; rdata_o shows the head entry (valid when not empty)
//   full_o, empty_o     occupancy flags
//   count_o             occupancy 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers are AW bits wide, so they wrap modulo DEPTH (power of two).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter on the data-memory bus
// Purpose: decodes a 16-byte register window, queues bytes in a FIFO and
//          serialises them LSB first with start/stop bits. Optional even
//          parity bit when the macro UART_TX_PARITY_EN is defined.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    slave side of mmio_uart_tx_if (we/addr/wd in, rd/hit out, both combinational)
//   txd    serial output, idle high, registered
//   irq    registered "transmit complete": FIFO empty and FSM idle
module mmio_uart_tx
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_uart_tx_if.slave        bus,
   output logic                 txd,
   output logic                 irq
);

   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [1:0]    ofs;
   logic          hit;
   logic          push_req;
   logic          fifo_pop;
   logic [7:0]    fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          busy;
   logic          baud_wrap;
   logic [31:0]   status;
   logic [31:0]   rdata;

   logic [15:0]   div_q, div_d;
   logic          ovf_q, ovf_d;
   tx_state_t     state_q;
   logic [15:0]   baud_q;
   logic [15:0]   div_sh_q;
   logic [2:0]    bit_q;
   logic [7:0]    data_q;
   logic          txd_q;
   logic          irq_q;

   logic          unused_bus;
   assign unused_bus = &{1'b0, bus.addr[1:0], bus.wd[31:16]};

   // ---------------- address decode and register file ----------------
   assign hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
   assign ofs      = bus.addr[3:2];
   assign push_req = bus.we & hit & (ofs == OFS_TXDATA);
   assign busy     = (state_q != IDLE);

   always_comb begin
      div_d = div_q;
      ovf_d = ovf_q;
      if (bus.we && hit && ofs == OFS_BAUDDIV) begin
         div_d = bus.wd[15:0];
      end
      if (bus.we && hit && ofs == OFS_STATUS && bus.wd[ST_OVF]) begin
         ovf_d = 1'b0;
      end
      // Dropped byte: full and nothing leaving this cycle.
      if (push_req && fifo_full && !fifo_pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= DEFAULT_DIV;
         ovf_q <= 1'b0;
      end else begin
         div_q <= div_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      status                       = '0;
      status[ST_BUSY]              = busy;
      status[ST_FULL]              = fifo_full;
      status[ST_EMPTY]             = fifo_empty;
      status[ST_OVF]               = ovf_q;
      status[ST_CNT_LSB +: 4]      = 4'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (ofs)
            OFS_STATUS:  rdata = status;
            OFS_BAUDDIV: rdata = {16'b0, div_q};
            default:     rdata = '0;
         endcase
      end
   end

   assign bus.rd  = rdata;
   assign bus.hit = hit;

   // ---------------- FIFO ----------------
   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_req),
      .wdata_i (bus.wd[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // ---------------- serialiser ----------------
   assign baud_wrap = (baud_q == div_sh_q);
   // A new frame is loaded from IDLE, or straight out of the last STOP cycle
   // so consecutive frames have no idle gap.
   assign fifo_pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_wrap));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         baud_q   <= '0;
         div_sh_q <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         txd_q    <= 1'b1;
         irq_q    <= 1'b1;
      end else begin
         irq_q <= fifo_empty & (state_q == IDLE);
         if (fifo_pop) begin
            data_q   <= fifo_rdata;
            div_sh_q <= div_q;
            baud_q   <= '0;
            state_q  <= START;
            txd_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  txd_q <= 1'b1;
               end
               START: begin
                  if (baud_wrap) begin
                     baud_q  <= '0;
                     bit_q   <= '0;
                     state_q <= DATA;
                     txd_q   <= data_q[0];
                  end else begin
                     baud_q <= baud_q + 16'd1;
                  end
               end
               DATA: begin
                  if (baud_wrap) begin
                     baud_q <= '0;
                     if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_q <= PARITY;
                        txd_q   <= ^data_q;
`else
                        state_q <= STOP;
                        txd_q   <= 1'b1;
`endif
                     end else begin
                        bit_q <= bit_q + 3'd1;
                        txd_q <= data_q[bit_q + 3'd1];
                     end
                  end else begin
                     baud_q <= baud_q + 16'd1;
                  end
               end
               PARITY: begin
                  if (baud_wrap) begin
                     baud_q  <= '0;
                     state_q <= STOP;
                     txd_q   <= 1'b1;
                  end else begin
                     baud_q <= baud_q + 16'd1;
                  end
               end
               STOP: begin
                  if (baud_wrap) begin
                     baud_q  <= '0;
                     state_q <= IDLE;
                     txd_q   <= 1'b1;
                  end else begin
                     baud_q <= baud_q + 16'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  txd_q   <= 1'b1;
               end
            endcase
         end
      end
   end

   assign txd = txd_q;
   assign irq = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
// Purpose: drives register writes/reads on the bus interface and checks every
//          txd bit-cycle of each frame against a bench-side frame model.
//          Parity frames are expected when UART_TX_PARITY_EN is defined.
module tb_mmio_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic clk;
   logic reset;
   logic txd;
   logic irq;
   int   checks;
   int   errors;

   mmio_uart_tx_if bus ();

   mmio_uart_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .txd   (txd),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge: presents the write, lets one rising edge capture it.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      bus.we   = 1'b1;
      bus.addr = a;
      bus.wd   = d;
      @(negedge clk);
      bus.we   = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      bus.we   = 1'b0;
      bus.addr = a;
      #1;
      d = bus.rd;
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // k0 = frame cycle (0 = first start-bit cycle) at the current negedge.
   task automatic check_frame(input logic [7:0] d, input int div, input int k0);
      for (int k = k0; k < NBITS * (div + 1); k++) begin
         check($sformatf("frame_%02h_k%0d", d, k), {31'b0, txd}, {31'b0, exp_bit(d, k / (div + 1))});
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      int n;
      n = 0;
      while (irq !== 1'b1 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'b0, (n < max_cycles)}, 32'd1);
   endtask

   logic [31:0] r;

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.we   = 1'b0;
      bus.addr = '0;
      bus.wd   = '0;
      repeat (2) @(negedge clk);
      check("rst_txd", {31'b0, txd}, 32'd1);
      check("rst_irq", {31'b0, irq}, 32'd1);
      reset = 1'b0;
      @(negedge clk);
      bus_read(32'h404, r); check("rst_status", r, 32'h04);
      bus_read(32'h408, r); check("rst_div", r, 32'd433);

      // 1: single byte at DIV=2, latency and irq 1->0->1
      bus_write(32'h408, 32'd2);
      bus_write(32'h400, 32'h55);
      check("t1_pre_txd", {31'b0, txd}, 32'd1);
      check("t1_pre_irq", {31'b0, irq}, 32'd1);
      @(negedge clk);
      check("t1_irq_busy", {31'b0, irq}, 32'd0);
      check_frame(8'h55, 2, 0);
      check("t1_end_txd", {31'b0, txd}, 32'd1);
      check("t1_end_irq_lag", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("t1_end_irq", {31'b0, irq}, 32'd1);

      // 2: three back-to-back bytes, contiguous frames
      bus_write(32'h400, 32'h41);
      bus_write(32'h400, 32'h42);
      bus_write(32'h400, 32'h43);
      bus_read(32'h404, r); check("t2_status_2", r, 32'h21);
      check_frame(8'h41, 2, 1);
      bus_read(32'h404, r); check("t2_status_1", r, 32'h11);
      check_frame(8'h42, 2, 0);
      bus_read(32'h404, r); check("t2_status_0", r, 32'h05);
      check_frame(8'h43, 2, 0);
      wait_idle(20);

      // 3: overflow while busy, then W1C
      bus_write(32'h400, 32'h11);
      bus_write(32'h400, 32'hA0);
      bus_write(32'h400, 32'hA1);
      bus_write(32'h400, 32'hA2);
      bus_write(32'h400, 32'hA3);
      bus_write(32'h400, 32'hA4);
      bus_read(32'h404, r); check("t3_status_ovf", r, 32'h4B);
      bus_write(32'h404, 32'h8);
      bus_read(32'h404, r); check("t3_status_clr", r, 32'h43);
      wait_idle(400);
      bus_read(32'h404, r); check("t3_status_idle", r, 32'h04);

      // 4: BAUDDIV change mid-frame applies to the next frame only
      bus_write(32'h400, 32'h5A);
      bus_write(32'h400, 32'h0F);
      bus_write(32'h408, 32'd5);
      bus_read(32'h408, r); check("t4_div_rd", r, 32'd5);
      check_frame(8'h5A, 2, 1);
      check_frame(8'h0F, 5, 0);
      wait_idle(20);

      // 6: parity frames (8N1 frames in the default build)
      bus_write(32'h408, 32'd2);
      bus_write(32'h400, 32'h07);
      bus_write(32'h400, 32'h03);
      check_frame(8'h07, 2, 0);
      check_frame(8'h03, 2, 0);
      wait_idle(20);

      // 5: reset mid-DATA, then out-of-window write
      bus_write(32'h400, 32'h00);
      repeat (7) @(negedge clk);
      check("t5_mid_data", {31'b0, txd}, 32'd0);
      reset = 1'b1;
      #1;
      check("t5_rst_txd", {31'b0, txd}, 32'd1);
      check("t5_rst_irq", {31'b0, irq}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      bus_read(32'h404, r); check("t5_status", r, 32'h04);
      bus_read(32'h408, r); check("t5_div", r, 32'd433);
      bus_read(32'h40C, r); check("t5_rsvd_rd", r, 32'h0);
      check("t5_hit_in", {31'b0, bus.hit}, 32'd1);
      bus_read(32'h400, r); check("t5_txdata_rd", r, 32'h0);
      bus_read(32'h060, r); check("t5_miss_rd", r, 32'h0);
      check("t5_hit_out", {31'b0, bus.hit}, 32'd0);
      bus_write(32'h060, 32'h99);
      repeat (3) @(negedge clk);
      check("t5_miss_txd", {31'b0, txd}, 32'd1);
      bus_read(32'h404, r); check("t5_miss_status", r, 32'h04);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
